// File: rtl/sys_trap_stage_if.sv
// Handshake/bus bundle between execute, sys_trap_stage and commit.
// master = upstream/commit driver side, slave = the stage itself.
interface sys_trap_stage_if #(
  parameter int XLEN    = 64,
  parameter int CAUSE_W = 5,
  parameter int NUM_SRC = 2
);
  logic                       in_valid;
  logic                       in_ready;
  logic [1:0]                 priv;
  logic                       ecall_op;
  logic                       ebreak_op;
  logic                       mret_op;
  logic                       sret_op;
  logic                       csrrw_op;
  logic                       csrrs_op;
  logic                       csrrc_op;
  logic [11:0]                csr_addr;
  logic [CAUSE_W-1:0]         cause_in;
  logic [XLEN-1:0]            tval_in;
  logic [NUM_SRC-1:0]         src_exc;
  logic [NUM_SRC*CAUSE_W-1:0] src_cause;
  logic [NUM_SRC*XLEN-1:0]    src_tval;
  logic                       out_valid;
  logic                       out_ready;
  logic [CAUSE_W-1:0]         cause_out;
  logic [XLEN-1:0]            tval_out;
  logic                       trap_out;
  logic [31:0]                trap_count;

  modport master (
    output in_valid, priv, ecall_op, ebreak_op, mret_op, sret_op,
           csrrw_op, csrrs_op, csrrc_op, csr_addr, cause_in, tval_in,
           src_exc, src_cause, src_tval, out_ready,
    input  in_ready, out_valid, cause_out, tval_out, trap_out, trap_count
  );

  modport slave (
    input  in_valid, priv, ecall_op, ebreak_op, mret_op, sret_op,
           csrrw_op, csrrs_op, csrrc_op, csr_addr, cause_in, tval_in,
           src_exc, src_cause, src_tval, out_ready,
    output in_ready, out_valid, cause_out, tval_out, trap_out, trap_count
  );
endinterface

// File: rtl/sys_trap_stage.sv
// Prioritised trap/sys-op classifier with a 2-entry skid buffer toward commit.
// Optional trap counter enabled by defining SYS_TRAP_COUNT_EN.
module sys_trap_stage #(
  parameter int XLEN    = 64,
  parameter int CAUSE_W = 5,
  parameter int NUM_SRC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  sys_trap_stage_if.slave  bus
);
  localparam logic [CAUSE_W-1:0] SYSOP_EBREAK            = CAUSE_W'(3);
  localparam logic [CAUSE_W-1:0] SYSOP_ECALL_FROM_U_MODE = CAUSE_W'(8);
  localparam logic [CAUSE_W-1:0] SYSOP_ECALL_FROM_S_MODE = CAUSE_W'(9);
  localparam logic [CAUSE_W-1:0] SYSOP_ECALL_FROM_M_MODE = CAUSE_W'(11);
  localparam logic [CAUSE_W-1:0] SYSOP_RET               = CAUSE_W'(16);
  localparam logic [CAUSE_W-1:0] SYSOP_CSR_W             = CAUSE_W'(17);
  localparam logic [CAUSE_W-1:0] SYSOP_CSR_S             = CAUSE_W'(18);
  localparam logic [CAUSE_W-1:0] SYSOP_CSR_C             = CAUSE_W'(19);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} fill_e;

  fill_e              state_q, state_d;
  logic               block_q, block_d;
  logic [CAUSE_W-1:0] cause0_q, cause0_d, cause1_q, cause1_d;
  logic [XLEN-1:0]    tval0_q, tval0_d, tval1_q, tval1_d;
  logic               trap0_q, trap0_d, trap1_q, trap1_d;

  logic [CAUSE_W-1:0] new_cause;
  logic [XLEN-1:0]    new_tval;
  logic               new_trap;
  logic               src_hit;
  logic               push, pop;

  always_comb begin
    new_cause = '0;
    new_tval  = '0;
    new_trap  = 1'b0;
    src_hit   = 1'b0;
    if (bus.cause_in != '0) begin
      new_cause = bus.cause_in;
      new_tval  = bus.tval_in;
      new_trap  = 1'b1;
    end else if (|bus.src_exc) begin
      new_trap = 1'b1;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (bus.src_exc[i] && !src_hit) begin
          src_hit   = 1'b1;
          new_cause = bus.src_cause[i*CAUSE_W +: CAUSE_W];
          new_tval  = bus.src_tval[i*XLEN +: XLEN];
        end
      end
    end else if (bus.ecall_op) begin
      new_trap = 1'b1;
      case (bus.priv)
        2'b00:   new_cause = SYSOP_ECALL_FROM_U_MODE;
        2'b01:   new_cause = SYSOP_ECALL_FROM_S_MODE;
        default: new_cause = SYSOP_ECALL_FROM_M_MODE;
      endcase
    end else if (bus.ebreak_op) begin
      new_trap  = 1'b1;
      new_cause = SYSOP_EBREAK;
    end else if (bus.mret_op || bus.sret_op) begin
      new_cause = SYSOP_RET;
    end else if (bus.csrrw_op) begin
      new_cause = SYSOP_CSR_W;
      new_tval  = XLEN'(bus.csr_addr);
    end else if (bus.csrrs_op) begin
      new_cause = SYSOP_CSR_S;
      new_tval  = XLEN'(bus.csr_addr);
    end else if (bus.csrrc_op) begin
      new_cause = SYSOP_CSR_C;
      new_tval  = XLEN'(bus.csr_addr);
    end
  end

  assign bus.in_ready  = (state_q != ST_FULL) && !block_q;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.cause_out = cause0_q;
  assign bus.tval_out  = tval0_q;
  assign bus.trap_out  = trap0_q;

  assign push = bus.in_valid && bus.in_ready && !flush;
  assign pop  = bus.out_valid && bus.out_ready && !flush;

  // Head registers are only rewritten on an incoming entry or a shift from
  // slot 1, so the head holds its last value once the buffer drains.
  always_comb begin
    state_d  = state_q;
    block_d  = block_q;
    cause0_d = cause0_q;
    tval0_d  = tval0_q;
    trap0_d  = trap0_q;
    cause1_d = cause1_q;
    tval1_d  = tval1_q;
    trap1_d  = trap1_q;
    if (flush) begin
      state_d = ST_EMPTY;
      block_d = 1'b0;
    end else begin
      if (push && new_trap) block_d = 1'b1;
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            cause0_d = new_cause;
            tval0_d  = new_tval;
            trap0_d  = new_trap;
            state_d  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push) begin
            if (pop) begin
              cause0_d = new_cause;
              tval0_d  = new_tval;
              trap0_d  = new_trap;
            end else begin
              cause1_d = new_cause;
              tval1_d  = new_tval;
              trap1_d  = new_trap;
              state_d  = ST_FULL;
            end
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            cause0_d = cause1_q;
            tval0_d  = tval1_q;
            trap0_d  = trap1_q;
            state_d  = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      block_q  <= 1'b0;
      cause0_q <= '0;
      tval0_q  <= '0;
      trap0_q  <= 1'b0;
      cause1_q <= '0;
      tval1_q  <= '0;
      trap1_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      block_q  <= block_d;
      cause0_q <= cause0_d;
      tval0_q  <= tval0_d;
      trap0_q  <= trap0_d;
      cause1_q <= cause1_d;
      tval1_q  <= tval1_d;
      trap1_q  <= trap1_d;
    end
  end

`ifdef SYS_TRAP_COUNT_EN
  logic [31:0] trap_cnt_q, trap_cnt_d;

  always_comb begin
    trap_cnt_d = trap_cnt_q;
    if (push && new_trap) trap_cnt_d = trap_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap_cnt_q <= '0;
    else     trap_cnt_q <= trap_cnt_d;
  end

  assign bus.trap_count = trap_cnt_q;
`else
  assign bus.trap_count = '0;
`endif
endmodule
